// File: rtl/instruction_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_arbiter
// Purpose  : Round-robin sharing of one combinational-read instruction cache
//            among NUM_REQ fetch units, one fetch in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_BITS = 8,
    parameter int WORD_BITS = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [WORD_BITS-1:0]           rsp_data_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [ADDR_BITS-1:0]           cache_addr_o,
    input  logic [WORD_BITS-1:0]           cache_rd_data_i
);

    localparam int PTR_BITS = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [PTR_BITS-1:0]    r_owner;
    logic [PTR_BITS-1:0]    r_ptr;
    logic [ADDR_BITS-1:0]   r_cache_addr;

    logic [ADDR_BITS-1:0]   w_addr [NUM_REQ];
    logic                   w_slot_free;
    logic                   w_found;
    logic                   w_accept;
    logic [PTR_BITS-1:0]    w_grant;
    logic [PTR_BITS-1:0]    w_next_ptr;
    logic [PTR_BITS:0]      w_idx;
    logic [NUM_REQ-1:0]     w_grant_onehot;

    generate
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
            assign w_addr[r] = req_addr_i[r*ADDR_BITS +: ADDR_BITS];
        end
    endgenerate

    // The slot frees up on the same edge the held response is consumed,
    // which is what allows one fetch per cycle under back-to-back traffic.
    assign w_slot_free = (r_state == S_EMPTY) |
                         (rsp_valid_o[r_owner] & rsp_ready_i[r_owner]);

    // Scan starts at the priority pointer and wraps modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (PTR_BITS+1)'(i);
            if (w_idx >= (PTR_BITS+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_BITS+1)'(NUM_REQ);
            end
            if (!w_found && req_valid_i[w_idx[PTR_BITS-1:0]]) begin
                w_grant = w_idx[PTR_BITS-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_accept       = w_slot_free & w_found;
    assign w_grant_onehot = (NUM_REQ)'(1) << w_grant;
    assign w_next_ptr     = (w_grant == PTR_BITS'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

    assign req_ready_o  = w_accept ? w_grant_onehot : '0;
    assign rsp_valid_o  = (r_state == S_FULL) ? ((NUM_REQ)'(1) << r_owner) : '0;
    assign rsp_data_o   = cache_rd_data_i;
    assign cache_addr_o = r_cache_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_EMPTY;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_cache_addr <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_cache_addr <= w_addr[w_grant];
                        r_owner      <= w_grant;
                        r_ptr        <= w_next_ptr;
                        r_state      <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_accept) begin
                        r_cache_addr <= w_addr[w_grant];
                        r_owner      <= w_grant;
                        r_ptr        <= w_next_ptr;
                    end else if (rsp_ready_i[r_owner]) begin
                        r_state      <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_arbiter
// Purpose  : Scoreboard bench for instruction_fetch_arbiter with a cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_addr  = '0;
    logic [3:0]  rsp_ready = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  cache_addr;
    logic [31:0] cache_rd_data;
    logic [31:0] mem [64];

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          stamp;
    } rsp_t;

    rsp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   m_ptr      = 0;
    int   m_owner    = 0;
    bit   m_full     = 1'b0;

    instruction_fetch_arbiter #(
        .NUM_REQ  (4),
        .ADDR_BITS(8),
        .WORD_BITS(32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_ready_i    (rsp_ready),
        .cache_addr_o   (cache_addr),
        .cache_rd_data_i(cache_rd_data)
    );

    assign cache_rd_data = mem[cache_addr[7:2]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: the front entry becomes visible one cycle after its accept.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].stamp < cyc) begin
                chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << sb[0].owner));
                chk("rsp_data", 64'(rsp_data), 64'(sb[0].data));
                if (rsp_ready[sb[0].owner]) void'(sb.pop_front());
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'd0);
            end
        end
    end

    // One cycle of stimulus; the reference model predicts the grant and queues the response.
    task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [3:0] rr);
        logic [3:0] exp_ready;
        bit         slot_free;
        int         g;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        @(negedge clk);
        slot_free = !m_full || rr[m_owner];
        exp_ready = '0;
        g = -1;
        if (slot_free) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (m_full && rr[m_owner]) m_full = 1'b0;
        if (g >= 0) begin
            logic [7:0] ad;
            ad = a[g*8 +: 8];
            sb.push_back('{owner: g, data: mem[ad[7:2]], stamp: cyc});
            m_full  = 1'b1;
            m_owner = g;
            m_ptr   = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cache_addr", 64'(cache_addr), 64'd0);
        sb.delete();
        m_full  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        #12;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_cache_addr", 64'(cache_addr), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;

        // Single requester, address 0x08
        step(4'b0001, 32'h0000_0008, 4'b1111);
        step(4'b0000, 32'h0,         4'b0000);
        // Async reset while a response is held, then ptr restarts at 0
        async_reset();
        step(4'b0110, 32'h0C08_0400, 4'b1111);
        step(4'b0000, 32'h0,         4'b1111);
        async_reset();

        // All requesters, full throughput: 0,1,2,3,0
        for (int i = 0; i < 5; i++) step(4'b1111, 32'h0C08_0400, 4'b1111);
        // Owner 1 stalls its response for three cycles
        step(4'b1111, 32'h0C08_0400, 4'b1111);
        for (int i = 0; i < 3; i++) step(4'b1111, 32'h0C08_0400, 4'b1101);
        step(4'b1111, 32'h0C08_0400, 4'b1111);
        // Wrap from requester 3 to 0
        step(4'b1001, 32'h3C00_0010, 4'b1111);
        step(4'b1001, 32'h3C00_0010, 4'b1111);
        // One-cycle pulse while the slot is busy
        step(4'b0100, 32'h0020_0000, 4'b0000);
        step(4'b0000, 32'h0,         4'b1111);
        step(4'b0000, 32'h0,         4'b1111);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] rr;
            rr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step(4'($urandom), $urandom, rr);
        end

        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 4'b1111);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
